// File: rtl/sa_pkg.sv
// sa_pkg: shared types, sizes and element extraction for the
// systolic result drainer slice.
package sa_pkg;

  localparam int NUM_ELEM   = 16;
  localparam int NUM_MAT    = 2;
  localparam int TOTAL_ELEM = NUM_ELEM * NUM_MAT;
  localparam int IDX_W      = 5;

  // widest element elem_at can return; callers zero-pad their bus
  localparam int MAX_W = 64;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  // element k of a row-major flat bus of w-bit elements
  function automatic logic [MAX_W-1:0] elem_at(
    input logic [NUM_ELEM*MAX_W-1:0] flat,
    input int k,
    input int w
  );
    logic [NUM_ELEM*MAX_W-1:0] sh;
    sh = flat >> (k * w);
    return sh[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sa_saturate.sv
// sa_saturate: clamps a signed ACC_W value to the signed WIDTH range.
// Ports: din (ACC_W, signed), dout (ACC_W, clamped, sign-extended).
module sa_saturate #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] dout
);

  localparam int HI_I = (1 << (WIDTH - 1)) - 1;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(HI_I);
  localparam logic signed [ACC_W-1:0] LO = ~HI;

  logic signed [ACC_W-1:0] s;

  assign s    = din;
  assign dout = (s > HI) ? HI : ((s < LO) ? LO : s);

endmodule

// File: rtl/sa_result_drainer.sv
// sa_result_drainer: snapshots both 4x4 result matrices on done_in and
// streams the 32 elements out over valid/ready (matrix 1 then matrix 2).
// Ports: clk, _reset_counter (async, active-low), done_in, res1_flat,
//   res2_flat, ovr_clr; out_valid/out_ready/out_data/out_mat/out_row/
//   out_col/out_last stream; busy, overrun (sticky dropped-done flag).
// Build option: RESULT_SAT_EN saturates elements to signed WIDTH at
//   snapshot time.
module sa_result_drainer
  import sa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic                      clk,
  input  logic                      _reset_counter,
  input  logic                      done_in,
  input  logic [NUM_ELEM*ACC_W-1:0] res1_flat,
  input  logic [NUM_ELEM*ACC_W-1:0] res2_flat,
  input  logic                      ovr_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic                      out_mat,
  output logic [1:0]                out_row,
  output logic [1:0]                out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int PAD = NUM_ELEM * (MAX_W - ACC_W);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [ACC_W-1:0] mem  [TOTAL_ELEM];
  logic [ACC_W-1:0] raw  [TOTAL_ELEM];
  logic [ACC_W-1:0] snap [TOTAL_ELEM];

  logic [NUM_ELEM*MAX_W-1:0] w1;
  logic [NUM_ELEM*MAX_W-1:0] w2;

  logic fire;
  logic at_last;
  logic take;
  logic ovr_ev;

  assign w1 = {{PAD{1'b0}}, res1_flat};
  assign w2 = {{PAD{1'b0}}, res2_flat};

  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_ext
    assign raw[k]          = ACC_W'(elem_at(w1, k, ACC_W));
    assign raw[k+NUM_ELEM] = ACC_W'(elem_at(w2, k, ACC_W));
  end

  for (genvar i = 0; i < TOTAL_ELEM; i++) begin : g_lane
`ifdef RESULT_SAT_EN
    sa_saturate #(
      .WIDTH (WIDTH),
      .ACC_W (ACC_W)
    ) u_sat (
      .din  (raw[i]),
      .dout (snap[i])
    );
`else
    assign snap[i] = raw[i];
`endif
  end

  assign fire    = out_valid & out_ready;
  assign at_last = idx == IDX_W'(TOTAL_ELEM - 1);

  // a new snapshot is accepted when idle, or on the final transfer
  // edge so back-to-back results see no bubble
  assign take = done_in &
    ((state == IDLE) | (fire & at_last));

  assign ovr_ev = done_in & (state == DRAIN) &
    ~(fire & at_last);

  always_ff @(posedge clk or negedge _reset_counter) begin
    if (!_reset_counter) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < TOTAL_ELEM; i++)
        mem[i] <= '0;
    end else begin
      if (ovr_ev)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;

      if (take) begin
        for (int i = 0; i < TOTAL_ELEM; i++)
          mem[i] <= snap[i];
      end

      unique case (state)
        IDLE: begin
          if (take) begin
            state     <= DRAIN;
            idx       <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          if (fire) begin
            if (!at_last) begin
              idx <= idx + 1'b1;
            end else if (take) begin
              idx <= '0;
            end else begin
              state     <= IDLE;
              idx       <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // stream fields decode from the registered index
  assign out_data = out_valid ? mem[idx] : '0;
  assign out_mat  = out_valid & idx[4];
  assign out_row  = out_valid ? idx[3:2] : 2'b00;
  assign out_col  = out_valid ? idx[1:0] : 2'b00;
  assign out_last = out_valid & at_last;

endmodule

// File: tb/tb_sa_result_drainer.sv
// tb_sa_result_drainer: randomized directed bench with a queue-based
// reference model of the 32-element drain order.
module tb_sa_result_drainer;

  localparam int W  = 8;
  localparam int AW = 2 * W;

  logic           clk = 1'b0;
  logic           _reset_counter = 1'b1;
  logic           done_in = 1'b0;
  logic [16*AW-1:0] res1_flat;
  logic [16*AW-1:0] res2_flat;
  logic           ovr_clr = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [AW-1:0]  out_data;
  logic           out_mat;
  logic [1:0]     out_row;
  logic [1:0]     out_col;
  logic           out_last;
  logic           busy;
  logic           overrun;

  logic signed [AW-1:0] m1 [16];
  logic signed [AW-1:0] m2 [16];

  typedef struct {
    logic [AW-1:0] d;
    logic          m;
    logic [1:0]    r;
    logic [1:0]    c;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  sa_result_drainer #(.WIDTH(W)) dut (
    .clk            (clk),
    ._reset_counter (_reset_counter),
    .done_in        (done_in),
    .res1_flat      (res1_flat),
    .res2_flat      (res2_flat),
    .ovr_clr        (ovr_clr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_mat        (out_mat),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_last       (out_last),
    .busy           (busy),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always_comb begin
    res1_flat = '0;
    res2_flat = '0;
    for (int k = 0; k < 16; k++) begin
      res1_flat[k*AW +: AW] = m1[k];
      res2_flat[k*AW +: AW] = m2[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_val(input int v);
`ifdef RESULT_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  function automatic logic [21:0] pack(input exp_t e);
    return {e.d, e.m, e.r, e.c, e.l};
  endfunction

  function automatic logic [21:0] cur_out();
    return {out_data, out_mat, out_row, out_col, out_last};
  endfunction

  // expected stream for one result pair, in matrix1-then-matrix2 order
  task automatic push_snapshot();
    for (int i = 0; i < 32; i++) begin
      exp_t e;
      int   v;
      v   = (i < 16) ? int'(m1[i]) : int'(m2[i-16]);
      v   = model_val(v);
      e.d = v[AW-1:0];
      e.m = (i / 16) == 1;
      e.r = 2'((i % 16) / 4);
      e.c = 2'(i % 4);
      e.l = (i == 31);
      exp_q.push_back(e);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < 16; k++) begin
      m1[k] = AW'($urandom);
      m2[k] = AW'($urandom);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    push_snapshot();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("first_busy", busy, 1);
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1
  task automatic drain(input int mode, input int inj, input bit b2b,
                       input int abort_at);
    int          cyc = 0;
    int          acc = 0;
    bit          stalled = 1'b0;
    bit          b2b_done = 1'b0;
    bit          rdy;
    logic [21:0] held = '0;
    logic [21:0] cur;
    exp_t        e;
    while (exp_q.size() > 0 && cyc <= 400) begin
      if (abort_at >= 0 && acc == abort_at) begin
        chk("abort_index", {27'd0, out_mat, out_row, out_col}, 10);
        _reset_counter = 1'b0;
        #1;
        chk("reset_outs",
            {cur_out(), out_valid, busy, overrun}, 0);
        exp_q.delete();
        break;
      end
      chk("valid_held", out_valid, 1);
      cur = cur_out();
      if (stalled) chk("stall_stable", cur, held);
      rdy = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      out_ready = rdy;
      done_in = 1'b0;
      if (cyc == inj) begin
        rand_data();
        done_in = 1'b1;
      end
      if (rdy) begin
        e = exp_q.pop_front();
        chk("elem", cur, pack(e));
        acc++;
        if (b2b && !b2b_done && exp_q.size() == 0) begin
          b2b_done = 1'b1;
          rand_data();
          m1[0] = -16'sd5;
          done_in = 1'b1;
          push_snapshot();
        end
      end
      stalled = !rdy;
      held = cur;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    done_in = 1'b0;
    chk("drain_complete", exp_q.size(), 0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      m1[k] = '0;
      m2[k] = '0;
    end
    #2;
    _reset_counter = 1'b0;
    #2;
    chk("reset_state",
        {cur_out(), out_valid, busy, overrun}, 0);
    _reset_counter = 1'b1;
    step();

    // basic drain
    for (int k = 0; k < 16; k++) begin
      m1[k] = AW'(k);
      m2[k] = AW'(100 + k);
    end
    start();
    drain(0, -1, 1'b0, -1);
    chk("idle_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_last", out_last, 0);

    // backpressure with random data
    rand_data();
    start();
    drain(1, -1, 1'b0, -1);
    chk("bp_idle_busy", busy, 0);

    // overrun: second done 11 cycles after the first
    rand_data();
    start();
    drain(0, 10, 1'b0, -1);
    chk("overrun_set", overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("overrun_clr", overrun, 0);

    // back-to-back snapshot on the final transfer edge
    rand_data();
    start();
    drain(0, -1, 1'b1, -1);
    chk("b2b_no_overrun", overrun, 0);
    chk("b2b_idle", busy, 0);

    // reset mid-drain at index 10
    rand_data();
    start();
    drain(0, -1, 1'b0, 10);
    _reset_counter = 1'b1;
    step();
    chk("post_reset_idle", out_valid, 0);
    rand_data();
    start();
    chk("restart_idx", {29'd0, out_mat, out_row, out_col}, 0);
    drain(0, -1, 1'b0, -1);

    // saturation boundary values
    rand_data();
    m1[0] = 16'sd300;
    m1[1] = -16'sd300;
    m1[2] = 16'sd50;
    m2[15] = -16'sd128;
    start();
    drain(1, -1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_result_drainer.md
Name: sa_result_drainer

Overview:
Sits downstream of the 4x4 dual-output systolic matrix multiplier and consumes its completion interface. It snapshots both 16-element accumulator result matrices on the multiplier's one-cycle done pulse. It then streams the 32 elements out one at a time over a valid/ready handshake to the softmax/scaling stage of the self-attention datapath. It flags any completion that arrives while a previous snapshot is still draining.

Parameters:
WIDTH, 8, operand width of the multiplier; results are 2*WIDTH signed.
ACC_W, 2*WIDTH, result element width (derived; do not override independently).

Ports:
clk  input  1  clock, rising edge.
_reset_counter  input  1  reset, asynchronous, active-low.
done_in  input  1  multiplier completion pulse; results valid in the same cycle.
res1_flat  input  16*ACC_W  matrix-1 results, element k (row-major, k=4*row+col) at bits [k*ACC_W +: ACC_W], signed.
res2_flat  input  16*ACC_W  matrix-2 results, same packing.
ovr_clr  input  1  synchronous clear of the overrun flag.
out_valid  output  1  out_data holds a valid element.
out_ready  input  1  downstream accepts the element this cycle.
out_data  output  ACC_W  current element, signed.
out_mat  output  1  0 = matrix 1, 1 = matrix 2.
out_row  output  2  row index of the current element.
out_col  output  2  column index of the current element.
out_last  output  1  high with element 31 (matrix 2, row 3, col 3).
busy  output  1  high while in DRAIN.
overrun  output  1  sticky; a done_in pulse was dropped.

Behaviour:
- Reset (async, _reset_counter=0):
  - state=IDLE, index=0, snapshot buffers=0.
  - out_valid, out_data, out_mat, out_row, out_col, out_last, busy, overrun all 0.
  - Reset mid-drain abandons the snapshot immediately.
- States: IDLE, DRAIN.
- IDLE with done_in=1 at edge T:
  - Register res1_flat/res2_flat into a 32-entry buffer; index=0; go to DRAIN.
  - out_valid=1 and busy=1 from T+1. Latency from done to first element is 1 cycle.
- DRAIN:
  - out_data=buffer[index]; out_mat=index[4]; out_row=index[3:2]; out_col=index[1:0]; out_last=(index==31).
  - All outputs are registered or decoded from registered index; nothing is combinational from inputs.
- Transfer occurs on an edge where out_valid && out_ready:
  - index<31: index+1.
  - index==31: go to IDLE and drop out_valid/busy, unless done_in is 1 at that same edge. In that case take a new snapshot, index=0, stay in DRAIN with out_valid continuously high (back-to-back, no bubble).
- out_valid is never withdrawn before a transfer. out_data and indices are held stable while out_valid && !out_ready.
- done_in while in DRAIN (other than the final-transfer edge):
  - Snapshot is NOT updated and the current drain continues unaffected.
  - overrun set to 1 from the next cycle.
- overrun clears only on ovr_clr=1 or reset. If ovr_clr and a new overrun event coincide, set wins.
- Throughput: 1 element/cycle, 32 cycles minimum per result pair. The multiplier completes every 11 cycles, so upstream must throttle; overrun exposes any violation.
- Element order is fixed: matrix 1 k=0..15, then matrix 2 k=0..15.

Optional Feature:
RESULT_SAT_EN:
- Defined: out_data is the element saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1] and sign-extended to ACC_W. Saturation is applied at snapshot time, so there is no added latency.
- Undefined: out_data is the raw ACC_W element.
- Handshake and ordering are identical in both builds.

Decomposition:
- Shared package sa_pkg:
  - NUM_ELEM=16, NUM_MAT=2, TOTAL_ELEM=32, IDX_W=5.
  - State typedef {IDLE, DRAIN}.
  - Function for element k extraction from a flat bus.
- Sub-module sa_saturate (ACC_W in, WIDTH clamp, ACC_W out), instantiated per snapshot lane under RESULT_SAT_EN.

Test Plan:
- Basic drain: res1 k-th element = k, res2 k-th element = 100+k, done_in pulse, out_ready=1 -> out_valid at T+1; 32 consecutive elements 0..15, 100..115; out_last only on 115; busy falls after the final transfer.
- Backpressure: out_ready toggles 1,0,0,1 per cycle during the drain -> no element is skipped or duplicated; data and indices are stable during stalls; the drain completes in 32 accepted transfers.
- Overrun: second done_in 11 cycles after the first, with different data -> original 32 values are delivered unchanged, overrun=1 afterwards; ovr_clr pulse -> overrun=0.
- Back-to-back: done_in on the same edge as the element-31 transfer, new res1[0]=-5 -> out_valid stays high; the next element is -5 with out_mat=0, row=0, col=0; overrun stays 0.
- Reset mid-drain: assert _reset_counter=0 at index 10 -> all outputs 0 asynchronously; after release, a new done_in drains from index 0.
- RESULT_SAT_EN build with WIDTH=8: elements 300, -300, 50 -> out_data 127, -128, 50 (sign-extended to 16 bits).
